ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe_pkg.sv | 52 +++++
 rtl/ex_mem_pipe_entry.sv | 33 +++
 rtl/ex_mem_pipe.sv | 151 +++++++++++++++
 tb/tb_ex_mem_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pipe_pkg.sv
// Shared EX->MEM types: register/memory bus views, the pipeline packet and its width,
// plus the write-enable sanitiser applied to every packet entering the stage.
package ex_mem_pipe_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_ADDR_W = 32;
  localparam int PKG_REG_AW = 5;
  localparam int PKG_OPC_W  = 7;

  typedef struct packed {
    logic                  we;
    logic [PKG_REG_AW-1:0] waddr;
    logic [PKG_DATA_W-1:0] wdata;
  } reg_bus_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
  } mem_bus_t;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] mem_wdata;
    logic [PKG_ADDR_W-1:0] mem_addr;
    logic                  mem_we;
    logic                  mem_req;
    logic [PKG_DATA_W-1:0] reg_wdata;
    logic                  reg_we;
    logic [PKG_REG_AW-1:0] reg_waddr;
    logic [PKG_OPC_W-1:0]  opcode;
  } ex_mem_pkt_t;

  localparam int PKT_W = $bits(ex_mem_pkt_t);

  // Register 0 is hardwired, so a write to it must never be stored as a real write.
  function automatic ex_mem_pkt_t sanitize_pkt(input ex_mem_pkt_t p);
    ex_mem_pkt_t r;
    r = p;
    if (p.reg_waddr == '0) r.reg_we = 1'b0;
    return r;
  endfunction

  function automatic reg_bus_t pkt_reg_bus(input ex_mem_pkt_t p);
    reg_bus_t b;
    b.we    = p.reg_we;
    b.waddr = p.reg_waddr;
    b.wdata = p.reg_wdata;
    return b;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_entry.sv
// One pipeline slot: valid flag plus payload; clear drops valid only so the payload stays stable.
// Single-cycle load; no flow control of its own, the owner decides when to load or clear.
module pipe_entry
  import ex_mem_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  ex_mem_pkt_t i_pkt,
  output logic        o_valid,
  output ex_mem_pkt_t o_pkt
);

  logic        r_valid;
  ex_mem_pkt_t r_pkt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pkt   <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pkt   <= i_pkt;
    end
  end

  assign o_valid = r_valid;
  assign o_pkt   = r_pkt;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with optional skid slot, register forwarding taps and a stall counter.
// One-cycle latency; with SKID_EN in_ready_o is registered (!S.valid), otherwise it is !M.valid | out_ready_i.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W  = PKG_DATA_W,
  parameter int ADDR_W  = PKG_ADDR_W,
  parameter int REG_AW  = PKG_REG_AW,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  ex_mem_pkt_t       in_pkt_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output ex_mem_pkt_t       out_pkt_o,
  output logic              fwd_ex_we_o,
  output logic [REG_AW-1:0] fwd_ex_addr_o,
  output logic [DATA_W-1:0] fwd_ex_data_o,
  output logic              fwd_mem_we_o,
  output logic [REG_AW-1:0] fwd_mem_addr_o,
  output logic [DATA_W-1:0] fwd_mem_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The packet layout is fixed by the package; the width parameters only document it.
  if (DATA_W != PKG_DATA_W || ADDR_W != PKG_ADDR_W || REG_AW != PKG_REG_AW) begin : g_width_chk
    $error("ex_mem_pipe: DATA_W/ADDR_W/REG_AW must match ex_mem_pipe_pkg");
  end

  ex_mem_pkt_t w_in_pkt;
  logic        w_in_xfer;
  logic        w_out_xfer;

  logic        w_m_valid;
  ex_mem_pkt_t w_m_pkt;
  logic        w_m_load;
  logic        w_m_clr;
  ex_mem_pkt_t w_m_din;

  reg_bus_t    w_ex_reg;
  reg_bus_t    w_mem_reg;

  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in_pkt   = sanitize_pkt(in_pkt_i);
  assign w_in_xfer  = in_valid_i & in_ready_o;
  assign w_out_xfer = w_m_valid & out_ready_i;

  pipe_entry u_m (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_m_clr),
    .i_load  (w_m_load),
    .i_pkt   (w_m_din),
    .o_valid (w_m_valid),
    .o_pkt   (w_m_pkt)
  );

  if (SKID_EN != 0) begin : g_skid
    logic        w_s_valid;
    ex_mem_pkt_t w_s_pkt;
    logic        w_s_load;
    logic        w_s_clr;

    pipe_entry u_s (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_s_clr),
      .i_load  (w_s_load),
      .i_pkt   (w_in_pkt),
      .o_valid (w_s_valid),
      .o_pkt   (w_s_pkt)
    );

    // S only fills while M is stalled, so S valid implies M valid and in_ready_o low.
    always_comb begin
      w_m_load = 1'b0;
      w_m_clr  = 1'b0;
      w_m_din  = w_in_pkt;
      w_s_load = 1'b0;
      w_s_clr  = 1'b0;
      if (flush_i) begin
        w_m_clr = 1'b1;
        w_s_clr = 1'b1;
      end else if (!w_m_valid || w_out_xfer) begin
        if (w_s_valid) begin
          w_m_load = 1'b1;
          w_m_din  = w_s_pkt;
          w_s_clr  = 1'b1;
        end else if (w_in_xfer) begin
          w_m_load = 1'b1;
        end else if (w_out_xfer) begin
          w_m_clr = 1'b1;
        end
      end else if (w_in_xfer) begin
        w_s_load = 1'b1;
      end
    end

    assign in_ready_o = !w_s_valid;
  end else begin : g_single
    always_comb begin
      w_m_load = 1'b0;
      w_m_clr  = 1'b0;
      w_m_din  = w_in_pkt;
      if (flush_i) begin
        w_m_clr = 1'b1;
      end else if (w_in_xfer) begin
        w_m_load = 1'b1;
      end else if (w_out_xfer) begin
        w_m_clr = 1'b1;
      end
    end

    assign in_ready_o = !w_m_valid | out_ready_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_m_valid && !out_ready_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_ex_reg    = pkt_reg_bus(in_pkt_i);
    w_ex_reg.we = in_valid_i & in_pkt_i.reg_we & (in_pkt_i.reg_waddr != '0) & !flush_i;
  end

  always_comb begin
    w_mem_reg    = pkt_reg_bus(w_m_pkt);
    w_mem_reg.we = w_m_valid & w_m_pkt.reg_we;
  end

  assign out_valid_o    = w_m_valid;
  assign out_pkt_o      = w_m_pkt;
  assign fwd_ex_we_o    = w_ex_reg.we;
  assign fwd_ex_addr_o  = w_ex_reg.waddr;
  assign fwd_ex_data_o  = w_ex_reg.wdata;
  assign fwd_mem_we_o   = w_mem_reg.we;
  assign fwd_mem_addr_o = w_mem_reg.waddr;
  assign fwd_mem_data_o = w_mem_reg.wdata;
  assign stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: skid instance (default widths) plus a single-entry,
// 4-bit-counter instance sharing the same inputs for saturation and ready-path checks.
module tb_ex_mem_pipe;
  import ex_mem_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        out_ready_i = 1'b1;
  ex_mem_pkt_t in_pkt_i = '0;

  logic        in_ready_o, out_valid_o;
  ex_mem_pkt_t out_pkt_o;
  logic        fwd_ex_we_o, fwd_mem_we_o;
  logic [4:0]  fwd_ex_addr_o, fwd_mem_addr_o;
  logic [31:0] fwd_ex_data_o, fwd_mem_data_o;
  logic [15:0] stall_cnt_o;

  logic        c4_in_ready, c4_out_valid;
  ex_mem_pkt_t c4_out_pkt;
  logic        c4_fwd_ex_we, c4_fwd_mem_we;
  logic [4:0]  c4_fwd_ex_addr, c4_fwd_mem_addr;
  logic [31:0] c4_fwd_ex_data, c4_fwd_mem_data;
  logic [3:0]  c4_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_pipe #(.SKID_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pkt_i(in_pkt_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pkt_o(out_pkt_o),
    .fwd_ex_we_o(fwd_ex_we_o), .fwd_ex_addr_o(fwd_ex_addr_o), .fwd_ex_data_o(fwd_ex_data_o),
    .fwd_mem_we_o(fwd_mem_we_o), .fwd_mem_addr_o(fwd_mem_addr_o), .fwd_mem_data_o(fwd_mem_data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  ex_mem_pipe #(.SKID_EN(0), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(c4_in_ready), .in_pkt_i(in_pkt_i),
    .out_valid_o(c4_out_valid), .out_ready_i(out_ready_i), .out_pkt_o(c4_out_pkt),
    .fwd_ex_we_o(c4_fwd_ex_we), .fwd_ex_addr_o(c4_fwd_ex_addr), .fwd_ex_data_o(c4_fwd_ex_data),
    .fwd_mem_we_o(c4_fwd_mem_we), .fwd_mem_addr_o(c4_fwd_mem_addr), .fwd_mem_data_o(c4_fwd_mem_data),
    .stall_cnt_o(c4_stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_mem_pkt_t mk(input logic [6:0] op, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic we);
    ex_mem_pkt_t p;
    p.opcode    = op;
    p.reg_waddr = wa;
    p.reg_wdata = wd;
    p.reg_we    = we;
    p.mem_req   = op[0];
    p.mem_we    = op[1];
    p.mem_addr  = 32'h0000_1000 + wd;
    p.mem_wdata = ~wd;
    return p;
  endfunction

  ex_mem_pkt_t pa, pz, pz_s, qa, qb, qc, pe, pf, pg, ph, pk;
  ex_mem_pkt_t ps[4];

  initial begin
    pa   = mk(7'h33, 5'd5, 32'h11, 1'b1);
    pz   = mk(7'h13, 5'd0, 32'hDEAD_BEEF, 1'b1);
    pz_s = mk(7'h13, 5'd0, 32'hDEAD_BEEF, 1'b0);
    qa   = mk(7'h03, 5'd1, 32'hA0A0_0001, 1'b1);
    qb   = mk(7'h23, 5'd2, 32'hB0B0_0002, 1'b1);
    qc   = mk(7'h63, 5'd3, 32'hC0C0_0003, 1'b0);
    pe   = mk(7'h01, 5'd7, 32'h0000_00E5, 1'b1);
    pf   = mk(7'h02, 5'd8, 32'h0000_00F6, 1'b1);
    pg   = mk(7'h33, 5'd9, 32'h0000_0067, 1'b1);
    ph   = mk(7'h37, 5'd10, 32'h0000_0048, 1'b1);
    pk   = mk(7'h6F, 5'd31, 32'hFFFF_0001, 1'b1);
    for (int i = 0; i < 4; i++) ps[i] = mk(7'(8 + i), 5'(12 + i), 32'h5000 + 32'(i), 1'b1);

    // reset state
    #12;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_fwd_mem_we", fwd_mem_we_o, 0);
    chk("rst_out_pkt", out_pkt_o, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    rst_n = 1'b1;
    step();

    // single packet, one-cycle latency, forwarding taps
    in_pkt_i = pa; in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    chk("fwd_ex_we_a", fwd_ex_we_o, 1);
    chk("fwd_ex_addr_a", fwd_ex_addr_o, 5);
    chk("fwd_ex_data_a", fwd_ex_data_o, 32'h11);
    step();
    in_valid_i = 1'b0;
    chk("a_out_valid", out_valid_o, 1);
    chk("a_out_pkt", out_pkt_o, pa);
    chk("a_fwd_mem_addr", fwd_mem_addr_o, 5);
    chk("a_fwd_mem_data", fwd_mem_data_o, 32'h11);
    chk("a_fwd_mem_we", fwd_mem_we_o, 1);
    step();
    chk("a_drained", out_valid_o, 0);
    chk("a_pkt_held", out_pkt_o, pa);

    // write to register 0 is neutralised
    in_pkt_i = pz; in_valid_i = 1'b1;
    #1;
    chk("z_fwd_ex_we", fwd_ex_we_o, 0);
    step();
    in_valid_i = 1'b0;
    chk("z_out_pkt", out_pkt_o, pz_s);
    chk("z_out_reg_we", out_pkt_o.reg_we, 0);
    chk("z_fwd_mem_we", fwd_mem_we_o, 0);
    step();

    // back-to-back stream at full rate
    for (int i = 0; i < 4; i++) begin
      in_pkt_i = ps[i]; in_valid_i = 1'b1;
      step();
      chk($sformatf("stream_pkt%0d", i), out_pkt_o, ps[i]);
      chk($sformatf("stream_vld%0d", i), out_valid_o, 1);
      chk($sformatf("stream_rdy%0d", i), in_ready_o, 1);
    end
    in_valid_i = 1'b0;
    step();
    chk("stream_empty", out_valid_o, 0);

    // stall with skid: A in M, B in S, C waits
    out_ready_i = 1'b0;
    in_pkt_i = qa; in_valid_i = 1'b1;
    step();
    in_pkt_i = qb;
    step();
    in_pkt_i = qc;
    step();
    step();
    chk("skid_m_pkt", out_pkt_o, qa);
    chk("skid_out_valid", out_valid_o, 1);
    chk("skid_in_ready", in_ready_o, 0);
    chk("skid_stall_cnt", stall_cnt_o, 3);
    chk("single_in_ready_stall", c4_in_ready, 0);
    chk("single_stall_cnt", c4_stall_cnt, 3);
    out_ready_i = 1'b1;
    #1;
    chk("single_in_ready_comb", c4_in_ready, 1);
    chk("skid_in_ready_reg", in_ready_o, 0);
    step();
    chk("rel_pkt_b", out_pkt_o, qb);
    chk("rel_vld_b", out_valid_o, 1);
    chk("rel_rdy_b", in_ready_o, 1);
    step();
    chk("rel_pkt_c", out_pkt_o, qc);
    chk("rel_vld_c", out_valid_o, 1);
    in_valid_i = 1'b0;
    step();
    chk("rel_empty", out_valid_o, 0);
    chk("rel_stall_cnt", stall_cnt_o, 3);

    // flush with both entries full and a packet arriving
    out_ready_i = 1'b0;
    in_pkt_i = pe; in_valid_i = 1'b1;
    step();
    in_pkt_i = pf;
    step();
    chk("fl_in_ready_full", in_ready_o, 0);
    flush_i = 1'b1; in_pkt_i = pg;
    #1;
    chk("fl_fwd_ex_we", fwd_ex_we_o, 0);
    step();
    chk("fl_out_valid", out_valid_o, 0);
    chk("fl_in_ready", in_ready_o, 1);
    chk("fl_stall_kept", stall_cnt_o, 5);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();
    chk("fl_no_ghost", out_valid_o, 0);
    chk("fl_fwd_mem_we", fwd_mem_we_o, 0);

    // stall counter saturation on the 4-bit instance
    out_ready_i = 1'b0;
    in_pkt_i = ph; in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    repeat (9) step();
    chk("sat_c4_14", c4_stall_cnt, 14);
    repeat (11) step();
    chk("sat_c4_15", c4_stall_cnt, 15);
    chk("sat_main_25", stall_cnt_o, 25);
    chk("sat_held_pkt", out_pkt_o, ph);

    // asynchronous reset in the middle of a stall
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid_o, 0);
    chk("arst_in_ready", in_ready_o, 1);
    chk("arst_out_pkt", out_pkt_o, 0);
    chk("arst_stall_cnt", stall_cnt_o, 0);
    chk("arst_c4_stall", c4_stall_cnt, 0);
    #1;
    rst_n = 1'b1;
    in_pkt_i = pk; in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready_o, 1);
    step();
    in_valid_i = 1'b0;
    chk("post_rst_out_valid", out_valid_o, 1);
    chk("post_rst_out_pkt", out_pkt_o, pk);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
